// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - round-robin multi-channel ultrasonic ranger with echo timing and cm divider
// Optional per-channel 4-sample moving average: define ULTRASONIC_RANGER_AVG_EN.
`timescale 1ns/1ps
module ultrasonic_ranger #(
   parameter int N_CH    = 2,
   parameter int CLK_HZ  = 100_000_000,
   parameter int TRIG_US = 10,
   parameter int SLOT_US = 60_000,
   parameter int MAX_US  = 25_000,
   parameter int DIST_W  = 9,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk_100MHz,
   input  logic                     reset,
   input  logic [N_CH-1:0]          echo_in,
   output logic [N_CH-1:0]          trig_out,
   output logic [N_CH*DIST_W-1:0]   dist_cm,
   output logic                     dist_valid,
   output logic [CH_W-1:0]          dist_ch,
   output logic [N_CH-1:0]          timeout
);

   localparam int DIV  = CLK_HZ / 1_000_000;
   localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int EW   = $clog2(MAX_US + 1);
   localparam int TMAX = (TRIG_US > MAX_US) ? TRIG_US : MAX_US;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int SW   = $clog2(SLOT_US + 1);

   typedef enum logic [2:0] {
      S_TRIG, S_WAIT_RISE, S_MEASURE, S_DIVIDE, S_DONE, S_TOUT, S_GAP
   } state_t;

   state_t            state;
   logic [CH_W-1:0]   ch;
   logic [PW-1:0]     presc;
   logic [TW-1:0]     us_cnt;
   logic [SW-1:0]     slot_us;
   logic [EW-1:0]     echo_us;
   logic [DIST_W-1:0] quot;
   logic [N_CH-1:0]   sync1, sync2, echo_prev;
   logic [DIST_W-1:0] dist_q [N_CH];

   logic              tick, slot_done, echo_rise, echo_fall;
   logic              go_tout, go_done, start_trig;
   logic [CH_W-1:0]   next_ch, start_ch;
   logic [DIST_W-1:0] result;

   assign tick      = (presc == PW'(DIV - 1));
   assign slot_done = (slot_us == SW'(SLOT_US)) || (tick && (slot_us == SW'(SLOT_US - 1)));
   assign echo_rise = sync2[ch] & ~echo_prev[ch];
   assign echo_fall = ~sync2[ch] & echo_prev[ch];
   assign next_ch   = (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;

   assign go_tout = tick && (((state == S_WAIT_RISE) && !echo_rise && (us_cnt == TW'(MAX_US - 1))) ||
                             ((state == S_MEASURE) && !echo_fall && (echo_us == EW'(MAX_US - 1))));
   assign go_done = (state == S_DIVIDE) && !((32'(echo_us) >= 32'd58) && (quot != '1));

   // The post-reset TRIG entry is the only time TRIG is seen with every trigger low.
   assign start_trig = ((state == S_TRIG) && (trig_out == '0)) ||
                       (((state == S_GAP) || (state == S_DONE) || (state == S_TOUT)) && slot_done);
   assign start_ch   = (state == S_TRIG) ? ch : next_ch;

`ifdef ULTRASONIC_RANGER_AVG_EN
   logic [DIST_W-1:0] hist [N_CH][4];
   logic [N_CH-1:0]   hist_ok;
   logic [DIST_W+1:0] hist_sum;

   // An empty history behaves as if preloaded with four copies of the new quotient.
   assign hist_sum = hist_ok[ch] ? ({2'b00, hist[ch][1]} + {2'b00, hist[ch][2]} +
                                    {2'b00, hist[ch][3]} + {2'b00, quot})
                                 : {quot, 2'b00};
   assign result   = hist_sum[DIST_W+1:2];

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         hist_ok <= '0;
      end else if (go_tout) begin
         hist_ok[ch] <= 1'b0;
      end else if (go_done) begin
         hist_ok[ch] <= 1'b1;
         if (hist_ok[ch]) begin
            hist[ch][0] <= hist[ch][1];
            hist[ch][1] <= hist[ch][2];
            hist[ch][2] <= hist[ch][3];
            hist[ch][3] <= quot;
         end else begin
            for (int k = 0; k < 4; k++) hist[ch][k] <= quot;
         end
      end
   end
`else
   assign result = quot;
`endif

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state      <= S_TRIG;
         ch         <= '0;
         presc      <= '0;
         us_cnt     <= '0;
         slot_us    <= '0;
         echo_us    <= '0;
         quot       <= '0;
         sync1      <= '0;
         sync2      <= '0;
         echo_prev  <= '0;
         trig_out   <= '0;
         dist_valid <= 1'b0;
         dist_ch    <= '0;
         timeout    <= '0;
         for (int k = 0; k < N_CH; k++) dist_q[k] <= '0;
      end else begin
         sync1      <= echo_in;
         sync2      <= sync1;
         echo_prev  <= sync2;
         presc      <= tick ? '0 : presc + 1'b1;
         dist_valid <= 1'b0;
         if (tick && (slot_us != SW'(SLOT_US))) slot_us <= slot_us + 1'b1;

         case (state)
            S_TRIG: begin
               if (tick) begin
                  if (us_cnt == TW'(TRIG_US - 1)) begin
                     trig_out <= '0;
                     us_cnt   <= '0;
                     state    <= S_WAIT_RISE;
                  end else begin
                     us_cnt <= us_cnt + 1'b1;
                  end
               end
            end
            S_WAIT_RISE: begin
               if (echo_rise) begin
                  // A tick coinciding with the rise belongs to the pulse.
                  echo_us <= tick ? EW'(1) : '0;
                  state   <= S_MEASURE;
               end else if (tick) begin
                  us_cnt <= us_cnt + 1'b1;
               end
            end
            S_MEASURE: begin
               if (echo_fall) begin
                  quot  <= '0;
                  state <= S_DIVIDE;
               end else if (tick) begin
                  echo_us <= echo_us + 1'b1;
               end
            end
            S_DIVIDE: begin
               if (!go_done) begin
                  echo_us <= echo_us - EW'(58);
                  quot    <= quot + 1'b1;
               end
            end
            S_DONE, S_TOUT: state <= S_GAP;
            default: ;
         endcase

         if (go_tout) begin
            dist_q[ch]  <= '1;
            timeout[ch] <= 1'b1;
            dist_valid  <= 1'b1;
            dist_ch     <= ch;
            state       <= S_TOUT;
         end

         if (go_done) begin
            dist_q[ch]  <= result;
            timeout[ch] <= 1'b0;
            dist_valid  <= 1'b1;
            dist_ch     <= ch;
            state       <= S_DONE;
         end

         // Trigger rise restarts the prescaler and the slot so both are phase-locked to it.
         if (start_trig) begin
            ch       <= start_ch;
            trig_out <= N_CH'(1) << start_ch;
            presc    <= '0;
            us_cnt   <= '0;
            slot_us  <= '0;
            state    <= S_TRIG;
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_dist
      assign dist_cm[k*DIST_W +: DIST_W] = dist_q[k];
   end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - directed self-checking bench for ultrasonic_ranger
// Expected averaging results follow ULTRASONIC_RANGER_AVG_EN when it is defined.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

   logic        clk = 1'b0;
   logic        reset_a = 1'b1, reset_b = 1'b1, reset_c = 1'b1;
   logic [1:0]  echo_a = '0;
   logic [0:0]  echo_b = '0, echo_c = '0;
   logic [1:0]  trig_a, tout_a;
   logic [0:0]  trig_b, tout_b, trig_c, tout_c;
   logic [17:0] dist_a;
   logic [7:0]  dist_b;
   logic [8:0]  dist_c;
   logic        valid_a, valid_b, valid_c;
   logic [0:0]  ch_a, ch_b, ch_c;

   int vec = 0;
   int err = 0;
   int pcnt = 0;
   int t0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) pcnt <= pcnt + 1;

   ultrasonic_ranger #(.N_CH(2), .CLK_HZ(2_000_000), .TRIG_US(10), .SLOT_US(2000),
                       .MAX_US(1000), .DIST_W(9)) dut_a (
      .clk_100MHz(clk), .reset(reset_a), .echo_in(echo_a), .trig_out(trig_a),
      .dist_cm(dist_a), .dist_valid(valid_a), .dist_ch(ch_a), .timeout(tout_a));

   ultrasonic_ranger #(.N_CH(1), .CLK_HZ(1_000_000), .TRIG_US(10), .SLOT_US(30000),
                       .MAX_US(25000), .DIST_W(8)) dut_b (
      .clk_100MHz(clk), .reset(reset_b), .echo_in(echo_b), .trig_out(trig_b),
      .dist_cm(dist_b), .dist_valid(valid_b), .dist_ch(ch_b), .timeout(tout_b));

   ultrasonic_ranger #(.N_CH(1), .CLK_HZ(1_000_000), .TRIG_US(10), .SLOT_US(1500),
                       .MAX_US(2000), .DIST_W(9)) dut_c (
      .clk_100MHz(clk), .reset(reset_c), .echo_in(echo_c), .trig_out(trig_c),
      .dist_cm(dist_c), .dist_valid(valid_c), .dist_ch(ch_c), .timeout(tout_c));

   task automatic wait_valid(input int inst, input int budget, output int n, output bit got);
      got = 1'b0;
      n   = 0;
      while (!got && n < budget) begin
         @(negedge clk);
         n++;
         case (inst)
            0:       got = valid_a;
            1:       got = valid_b;
            default: got = valid_c;
         endcase
      end
   endtask

   task automatic wait_trig(input int inst, input int bitpos, input logic level,
                            input int budget, output bit got);
      logic v;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         case (inst)
            0:       v = trig_a[bitpos];
            1:       v = trig_b[0];
            default: v = trig_c[0];
         endcase
         got = (v === level);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vec++; if (trig_a !== 2'b00) begin err++; $display("FAIL reset_trig got=%b exp=00", trig_a); end
      vec++; if (dist_a !== 18'd0) begin err++; $display("FAIL reset_dist got=%h exp=0", dist_a); end
      vec++; if (valid_a !== 1'b0) begin err++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
      vec++; if (ch_a !== 1'b0) begin err++; $display("FAIL reset_ch got=%b exp=0", ch_a); end
      vec++; if (tout_a !== 2'b00) begin err++; $display("FAIL reset_timeout got=%b exp=00", tout_a); end
      reset_a = 1'b0;
      @(negedge clk);
      t0 = pcnt;
      vec++; if (trig_a !== 2'b01) begin err++; $display("FAIL first_trig got=%b exp=01", trig_a); end
   endtask

   task automatic test_trig_width;
      int n = 1;
      while (trig_a[0] === 1'b1 && n < 200) begin
         @(negedge clk);
         if (trig_a[0] === 1'b1) n++;
      end
      vec++; if (n !== 20) begin err++; $display("FAIL trig_width got=%0d exp=20", n); end
   endtask

   task automatic test_echo_580;
      int n; bit got;
      repeat (400) @(negedge clk);
      echo_a[0] = 1'b1;
      repeat (1160) @(negedge clk);
      echo_a[0] = 1'b0;
      wait_valid(0, 3000, n, got);
      vec++; if (got !== 1'b1) begin err++; $display("FAIL echo580_valid got=%b exp=1", got); end
      vec++; if (n !== 14) begin err++; $display("FAIL echo580_latency got=%0d exp=14", n); end
      vec++; if (ch_a !== 1'b0) begin err++; $display("FAIL echo580_ch got=%b exp=0", ch_a); end
      vec++; if (dist_a[8:0] !== 9'd10) begin err++; $display("FAIL echo580_dist got=%0d exp=10", dist_a[8:0]); end
      vec++; if (dist_a[17:9] !== 9'd0) begin err++; $display("FAIL echo580_other got=%0d exp=0", dist_a[17:9]); end
      vec++; if (tout_a !== 2'b00) begin err++; $display("FAIL echo580_timeout got=%b exp=00", tout_a); end
   endtask

   task automatic test_slot_period;
      bit got;
      wait_trig(0, 1, 1'b1, 5000, got);
      vec++; if (got !== 1'b1) begin err++; $display("FAIL slot_trig1 got=%b exp=1", got); end
      vec++; if (pcnt - t0 !== 4000) begin err++; $display("FAIL slot_period got=%0d exp=4000", pcnt - t0); end
      vec++; if (trig_a !== 2'b10) begin err++; $display("FAIL slot_onehot got=%b exp=10", trig_a); end
   endtask

   task automatic test_timeout_ch1;
      int n; bit got;
      wait_trig(0, 1, 1'b0, 100, got);
      echo_a[0] = 1'b1;
      wait_valid(0, 2500, n, got);
      echo_a[0] = 1'b0;
      vec++; if (got !== 1'b1) begin err++; $display("FAIL tout_valid got=%b exp=1", got); end
      vec++; if (n !== 2000) begin err++; $display("FAIL tout_latency got=%0d exp=2000", n); end
      vec++; if (ch_a !== 1'b1) begin err++; $display("FAIL tout_ch got=%b exp=1", ch_a); end
      vec++; if (dist_a[17:9] !== 9'd511) begin err++; $display("FAIL tout_dist got=%0d exp=511", dist_a[17:9]); end
      vec++; if (tout_a !== 2'b10) begin err++; $display("FAIL tout_flag got=%b exp=10", tout_a); end
      vec++; if (dist_a[8:0] !== 9'd10) begin err++; $display("FAIL tout_hold_ch0 got=%0d exp=10", dist_a[8:0]); end
   endtask

   task automatic test_boundary_999;
      int n; bit got;
      wait_trig(0, 0, 1'b1, 3000, got);
      wait_trig(0, 0, 1'b0, 100, got);
      repeat (10) @(negedge clk);
      echo_a[0] = 1'b1;
      repeat (1998) @(negedge clk);
      echo_a[0] = 1'b0;
      wait_valid(0, 100, n, got);
      vec++; if (n !== 21) begin err++; $display("FAIL b999_latency got=%0d exp=21", n); end
      vec++; if (dist_a[8:0] !== 9'd17) begin err++; $display("FAIL b999_dist got=%0d exp=17", dist_a[8:0]); end
      vec++; if (tout_a !== 2'b10) begin err++; $display("FAIL b999_timeout got=%b exp=10", tout_a); end
   endtask

   task automatic test_ch1_116;
      int n; bit got;
      wait_trig(0, 1, 1'b1, 4000, got);
      wait_trig(0, 1, 1'b0, 100, got);
      repeat (10) @(negedge clk);
      echo_a[1] = 1'b1;
      repeat (232) @(negedge clk);
      echo_a[1] = 1'b0;
      wait_valid(0, 100, n, got);
      vec++; if (n !== 6) begin err++; $display("FAIL c116_latency got=%0d exp=6", n); end
      vec++; if (ch_a !== 1'b1) begin err++; $display("FAIL c116_ch got=%b exp=1", ch_a); end
      vec++; if (dist_a[17:9] !== 9'd2) begin err++; $display("FAIL c116_dist got=%0d exp=2", dist_a[17:9]); end
      vec++; if (tout_a !== 2'b00) begin err++; $display("FAIL c116_timeout got=%b exp=00", tout_a); end
   endtask

   task automatic test_echo_hold;
      int n; bit got;
      wait_trig(0, 0, 1'b1, 4000, got);
      wait_trig(0, 0, 1'b0, 100, got);
      repeat (10) @(negedge clk);
      echo_a[0] = 1'b1;
      wait_valid(0, 2600, n, got);
      vec++; if (!(n >= 2001 && n <= 2002)) begin err++; $display("FAIL hold_latency got=%0d exp=2001..2002", n); end
      vec++; if (dist_a[8:0] !== 9'd511) begin err++; $display("FAIL hold_dist got=%0d exp=511", dist_a[8:0]); end
      vec++; if (tout_a !== 2'b01) begin err++; $display("FAIL hold_timeout got=%b exp=01", tout_a); end
      vec++; if (dist_a[17:9] !== 9'd2) begin err++; $display("FAIL hold_ch1_kept got=%0d exp=2", dist_a[17:9]); end
      if (n < 3000) repeat (3000 - n) @(negedge clk);
      echo_a[0] = 1'b0;
   endtask

   task automatic test_reset_mid;
      bit got;
      wait_trig(0, 0, 1'b1, 9000, got);
      vec++; if (got !== 1'b1) begin err++; $display("FAIL rmid_trig got=%b exp=1", got); end
      wait_trig(0, 0, 1'b0, 100, got);
      repeat (10) @(negedge clk);
      echo_a[0] = 1'b1;
      repeat (100) @(negedge clk);
      reset_a = 1'b1;
      @(negedge clk);
      vec++; if (trig_a !== 2'b00) begin err++; $display("FAIL rmid_trig0 got=%b exp=00", trig_a); end
      vec++; if (dist_a !== 18'd0) begin err++; $display("FAIL rmid_dist got=%h exp=0", dist_a); end
      vec++; if (valid_a !== 1'b0) begin err++; $display("FAIL rmid_valid got=%b exp=0", valid_a); end
      vec++; if (ch_a !== 1'b0) begin err++; $display("FAIL rmid_ch got=%b exp=0", ch_a); end
      vec++; if (tout_a !== 2'b00) begin err++; $display("FAIL rmid_timeout got=%b exp=00", tout_a); end
      reset_a = 1'b0;
      echo_a[0] = 1'b0;
      @(negedge clk);
      vec++; if (trig_a !== 2'b01) begin err++; $display("FAIL rmid_restart got=%b exp=01", trig_a); end
   endtask

   task automatic test_saturate;
      int n; bit got;
      reset_b = 1'b0;
      wait_trig(1, 0, 1'b1, 10, got);
      wait_trig(1, 0, 1'b0, 50, got);
      repeat (10) @(negedge clk);
      echo_b = 1'b1;
      repeat (24000) @(negedge clk);
      echo_b = 1'b0;
      wait_valid(1, 400, n, got);
      vec++; if (got !== 1'b1) begin err++; $display("FAIL sat_valid got=%b exp=1", got); end
      vec++; if (n !== 259) begin err++; $display("FAIL sat_latency got=%0d exp=259", n); end
      vec++; if (dist_b !== 8'd255) begin err++; $display("FAIL sat_dist got=%0d exp=255", dist_b); end
      vec++; if (tout_b !== 1'b0) begin err++; $display("FAIL sat_timeout got=%b exp=0", tout_b); end
   endtask

   task automatic test_average;
      int n; bit got;
      int lens [4] = '{580, 1160, 1160, 1160};
`ifdef ULTRASONIC_RANGER_AVG_EN
      int exps [4] = '{10, 12, 15, 17};
`else
      int exps [4] = '{10, 20, 20, 20};
`endif
      reset_c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_trig(2, 0, 1'b1, 2000, got);
         wait_trig(2, 0, 1'b0, 50, got);
         repeat (20) @(negedge clk);
         echo_c = 1'b1;
         repeat (lens[i]) @(negedge clk);
         echo_c = 1'b0;
         wait_valid(2, 100, n, got);
         vec++; if (got !== 1'b1) begin err++; $display("FAIL avg%0d_valid got=%b exp=1", i, got); end
         vec++; if (dist_c !== 9'(exps[i])) begin err++; $display("FAIL avg%0d_dist got=%0d exp=%0d", i, dist_c, exps[i]); end
      end
      vec++; if (tout_c !== 1'b0) begin err++; $display("FAIL avg_timeout got=%b exp=0", tout_c); end
   endtask

   initial begin
      test_reset;
      test_trig_width;
      test_echo_580;
      test_slot_period;
      test_timeout_ch1;
      test_boundary_999;
      test_ch1_116;
      test_echo_hold;
      test_reset_mid;
      test_saturate;
      test_average;
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired vectors=%0d errors=%0d", vec, err);
      $fatal(1);
   end

endmodule
